frame_stream_harness: RTL and testbench

//  Synthesizable frame traffic generator and checker for FIFO-wrapped pixel pipelines (grayscale, sobel).

---
 rtl/frame_stream_harness.sv | 232 +++++++++++++++++++++++
 tb/tb_frame_stream_harness.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_stream_harness.sv
// frame_stream_harness
//   Frame traffic generator and checker for FIFO-wrapped pixel pipelines.
//   The source side pushes one generated frame (ramp, constant or LFSR pattern)
//   into the DUT input FIFO while honouring full. The sink side drains the DUT
//   output FIFO (first-word-fall-through), counts pixels and RUN cycles, and
//   folds every consumed word into a rotate-xor checksum.
//
//   Optional build macro: STREAM_THROTTLE_EN
//     When defined, a free-running 16-bit LFSR gates both strobes to roughly
//     75% duty so the DUT sees bursty traffic and backpressure.
//     When undefined, the strobes depend only on state, counts, full and empty.
//
//   Parameter limits: IMG_WIDTH, IMG_HEIGHT >= 1,
//   CHANNELS*CH_WIDTH <= 32, OUT_CHANNELS*CH_WIDTH <= 32.

`timescale 1ns/1ps

module frame_stream_harness #(
    parameter int IMG_WIDTH    = 720,
    parameter int IMG_HEIGHT   = 540,
    parameter int CHANNELS     = 3,
    parameter int CH_WIDTH     = 8,
    parameter int OUT_CHANNELS = 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    input  logic [1:0]                       mode,
    input  logic [31:0]                      seed,
    output logic [CHANNELS*CH_WIDTH-1:0]     src_din,
    output logic                             src_wr_en,
    input  logic                             src_full,
    input  logic [OUT_CHANNELS*CH_WIDTH-1:0] snk_dout,
    input  logic                             snk_empty,
    output logic                             snk_rd_en,
    output logic                             busy,
    output logic                             done,
    output logic                             overrun,
    output logic [31:0]                      cycle_count,
    output logic [31:0]                      checksum
);

    localparam int          DIN_W      = CHANNELS * CH_WIDTH;
    localparam logic [31:0] PIX_TOTAL  = 32'(IMG_WIDTH * IMG_HEIGHT);
    localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
    localparam logic [31:0] RAMP_STEP  = 32'(CHANNELS);
    localparam logic [1:0]  MODE_CONST = 2'd1;
    localparam logic [1:0]  MODE_LFSR  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        start_ok;

    logic [31:0] src_cnt;
    logic [31:0] snk_cnt;
    logic [31:0] pat_reg;
    logic [31:0] pat_next;
    logic [1:0]  mode_reg;

    logic        src_open;
    logic        snk_open;
    logic        frame_complete;
    logic        src_gate;
    logic        snk_gate;

    assign src_open       = (src_cnt < PIX_TOTAL);
    assign snk_open       = (snk_cnt < PIX_TOTAL);
    assign frame_complete = (src_cnt == PIX_TOTAL) && (snk_cnt == PIX_TOTAL);

`ifdef STREAM_THROTTLE_EN
    logic [15:0] thr_lfsr;

    // Free-running Fibonacci LFSR (x^16+x^14+x^13+x^11+1) that throttles both sides.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            thr_lfsr <= 16'hACE1;
        end else begin
            thr_lfsr <= {thr_lfsr[0] ^ thr_lfsr[2] ^ thr_lfsr[3] ^ thr_lfsr[5], thr_lfsr[15:1]};
        end
    end

    assign src_gate = (thr_lfsr[1:0] != 2'b00);
    assign snk_gate = (thr_lfsr[3:2] != 2'b00);
`else
    assign src_gate = 1'b1;
    assign snk_gate = 1'b1;
`endif

    assign busy      = (state == ST_RUN);
    assign done      = (state == ST_DONE);
    assign src_wr_en = busy & src_open & ~src_full & src_gate;
    assign snk_rd_en = busy & snk_open & ~snk_empty & snk_gate;

    // State register; reset drops straight back to IDLE even mid-frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start is only honoured from IDLE or DONE.
    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    start_ok   = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (frame_complete) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    start_ok   = 1'b1;
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Pattern advance for one accepted write, selected by the latched mode.
    always_comb begin
        pat_next = pat_reg;
        case (mode_reg)
            MODE_CONST: pat_next = pat_reg;
            MODE_LFSR:  pat_next = {1'b0, pat_reg[31:1]} ^ (pat_reg[0] ? LFSR_TAPS : 32'h0);
            default:    pat_next = pat_reg + RAMP_STEP;
        endcase
    end

    // Source word: ramp expands the base into per-channel values, the others show the register.
    always_comb begin
        src_din = '0;
        if (busy) begin
            case (mode_reg)
                MODE_CONST, MODE_LFSR: begin
                    src_din = pat_reg[DIN_W-1:0];
                end
                default: begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        src_din[c*CH_WIDTH +: CH_WIDTH] = pat_reg[CH_WIDTH-1:0] + CH_WIDTH'(c);
                    end
                end
            endcase
        end
    end

    // Pattern register: loaded from mode/seed on an accepted start, stepped on every write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pat_reg  <= '0;
            mode_reg <= '0;
        end else if (start_ok) begin
            mode_reg <= mode;
            case (mode)
                MODE_CONST: pat_reg <= seed;
                MODE_LFSR:  pat_reg <= (seed == 32'h0) ? 32'h1 : seed;
                default:    pat_reg <= '0;
            endcase
        end else if (src_wr_en) begin
            pat_reg <= pat_next;
        end
    end

    // Source and sink pixel counters, cleared by an accepted start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            src_cnt <= '0;
            snk_cnt <= '0;
        end else if (start_ok) begin
            src_cnt <= '0;
            snk_cnt <= '0;
        end else begin
            if (src_wr_en) begin
                src_cnt <= src_cnt + 32'd1;
            end
            if (snk_rd_en) begin
                snk_cnt <= snk_cnt + 32'd1;
            end
        end
    end

    // RUN cycle counter, saturating at all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_count <= '0;
        end else if (start_ok) begin
            cycle_count <= '0;
        end else if (busy && (cycle_count != 32'hFFFF_FFFF)) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end

    // Rotate-left-by-one then xor in each consumed sink word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            checksum <= '0;
        end else if (start_ok) begin
            checksum <= '0;
        end else if (snk_rd_en) begin
            checksum <= {checksum[30:0], checksum[31]} ^ 32'(snk_dout);
        end
    end

    // Sticky flag for output data that shows up after the frame has finished.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (start_ok) begin
            overrun <= 1'b0;
        end else if (done && !snk_empty) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_frame_stream_harness.sv
// tb_frame_stream_harness
//   2x2 frame, 3 channels in and out, looped back through a depth-4 FWFT FIFO
//   modelled in the bench. Expected source words are queued when a frame is
//   started and popped as the harness writes them.

`timescale 1ns/1ps

module tb_frame_stream_harness;

    localparam int NPIX = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic [31:0] seed;
    logic [23:0] src_din;
    logic        src_wr_en;
    logic        src_full;
    logic [23:0] snk_dout;
    logic        snk_empty;
    logic        snk_rd_en;
    logic        busy;
    logic        done;
    logic        overrun;
    logic [31:0] cycle_count;
    logic [31:0] checksum;

    logic        force_full;
    logic        force_empty;
    logic        inject_en;
    logic        fifo_flush;
    logic [23:0] inject_data;
    logic [23:0] fifo_mem [4];
    logic [1:0]  fifo_wp;
    logic [1:0]  fifo_rp;
    logic [2:0]  fifo_cnt;
    logic        fifo_push;

    int          total = 0;
    int          bad   = 0;
    logic [23:0] exp_q [$];
    logic [31:0] exp_sum;

    always #5 clock = ~clock;

    frame_stream_harness #(
        .IMG_WIDTH   (2),
        .IMG_HEIGHT  (2),
        .CHANNELS    (3),
        .CH_WIDTH    (8),
        .OUT_CHANNELS(3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .seed       (seed),
        .src_din    (src_din),
        .src_wr_en  (src_wr_en),
        .src_full   (src_full),
        .snk_dout   (snk_dout),
        .snk_empty  (snk_empty),
        .snk_rd_en  (snk_rd_en),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun),
        .cycle_count(cycle_count),
        .checksum   (checksum)
    );

    assign src_full  = force_full | (fifo_cnt == 3'd4);
    assign snk_empty = force_empty | (fifo_cnt == 3'd0);
    assign snk_dout  = fifo_mem[fifo_rp];
    assign fifo_push = src_wr_en | inject_en;

    // Loopback FIFO, depth 4, first-word-fall-through.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            fifo_wp  <= '0;
            fifo_rp  <= '0;
            fifo_cnt <= '0;
        end else if (fifo_flush) begin
            fifo_wp  <= '0;
            fifo_rp  <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_push) begin
                fifo_mem[fifo_wp] <= inject_en ? inject_data : src_din;
                fifo_wp           <= fifo_wp + 2'd1;
            end
            if (snk_rd_en) begin
                fifo_rp <= fifo_rp + 2'd1;
            end
            fifo_cnt <= fifo_cnt + 3'(fifo_push) - 3'(snk_rd_en);
        end
    end

    // Overall time limit so the bench can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] galois(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [31:0] fold(input logic [31:0] sum, input logic [23:0] w);
        return {sum[30:0], sum[31]} ^ {8'h00, w};
    endfunction

    task automatic push_frame(input logic [1:0] m, input logic [31:0] s);
        logic [31:0] st;
        logic [23:0] w;
        exp_sum = 32'h0;
        st = (s == 32'h0) ? 32'h1 : s;
        for (int p = 0; p < NPIX; p++) begin
            case (m)
                2'd1: w = s[23:0];
                2'd2: begin
                    if (p != 0) st = galois(st);
                    w = st[23:0];
                end
                default: begin
                    w[7:0]   = 8'(p * 3);
                    w[15:8]  = 8'(p * 3 + 1);
                    w[23:16] = 8'(p * 3 + 2);
                end
            endcase
            exp_q.push_back(w);
            exp_sum = fold(exp_sum, w);
        end
    endtask

    task automatic to_negedge();
        logic [23:0] w;
        @(negedge clock);
        if (src_wr_en === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL sb_extra_write: got %h want no write", src_din);
            end else begin
                w = exp_q.pop_front();
                if (src_din !== w) begin
                    bad++;
                    $display("[TB] FAIL sb_src_din: got %h want %h", src_din, w);
                end
            end
        end
    endtask

    task automatic to_posedge();
        @(posedge clock);
        #1;
    endtask

    task automatic step();
        to_negedge();
        to_posedge();
    endtask

    task automatic pulse_start(input logic [1:0] m, input logic [31:0] s, input bit expect_accept);
        mode  = m;
        seed  = s;
        start = 1'b1;
        if (expect_accept) push_frame(m, s);
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s_done_timeout: got done=%b want 1", name, done);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL %s_sb_left: got %0d pending want 0", name, exp_q.size());
        end
        total++;
        if (checksum !== exp_sum) begin
            bad++;
            $display("[TB] FAIL %s_checksum: got %h want %h", name, checksum, exp_sum);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        to_posedge();
        total++;
        if ({busy, done, overrun, src_wr_en, snk_rd_en} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL reset_flags: got %b want 00000", {busy, done, overrun, src_wr_en, snk_rd_en});
        end
        total++;
        if (src_din !== 24'h0) begin
            bad++;
            $display("[TB] FAIL reset_src_din: got %h want 000000", src_din);
        end
        total++;
        if (cycle_count !== 32'h0 || checksum !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_counters: got %h/%h want 0/0", cycle_count, checksum);
        end
        to_posedge();
        reset = 1'b0;
        to_posedge();
    endtask

    task automatic test_ramp_frame();
        pulse_start(2'd0, 32'h0, 1'b1);
        wait_done("ramp", 50);
        total++;
        if (checksum !== 32'h001F_1C09) begin
            bad++;
            $display("[TB] FAIL ramp_checksum_const: got %h want 001f1c09", checksum);
        end
        total++;
        if (cycle_count !== 32'd6) begin
            bad++;
            $display("[TB] FAIL ramp_cycle_count: got %0d want 6", cycle_count);
        end
        to_negedge();
        total++;
        if ({busy, src_wr_en, snk_rd_en} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL done_strobes: got %b want 000", {busy, src_wr_en, snk_rd_en});
        end
        to_posedge();
    endtask

    task automatic test_full_backpressure();
        force_full = 1'b1;
        pulse_start(2'd0, 32'h0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            to_negedge();
            total++;
            if (src_wr_en !== 1'b0) begin
                bad++;
                $display("[TB] FAIL full_wr_en cycle %0d: got %b want 0", i, src_wr_en);
            end
            to_posedge();
        end
        force_full = 1'b0;
        @(negedge clock);
        total++;
        if (src_wr_en !== 1'b1 || fifo_cnt !== 3'd0) begin
            bad++;
            $display("[TB] FAIL full_resume: got wr_en=%b fifo=%0d want 1/0", src_wr_en, fifo_cnt);
        end
        total++;
        if (cycle_count !== 32'd10) begin
            bad++;
            $display("[TB] FAIL full_cycle_count: got %0d want 10", cycle_count);
        end
        to_negedge_same_time();
        to_posedge();
        wait_done("full", 50);
    endtask

    // Scoreboard pop at the current negedge without waiting for another one.
    task automatic to_negedge_same_time();
        logic [23:0] w;
        if (src_wr_en === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL sb_extra_write: got %h want no write", src_din);
            end else begin
                w = exp_q.pop_front();
                if (src_din !== w) begin
                    bad++;
                    $display("[TB] FAIL sb_src_din: got %h want %h", src_din, w);
                end
            end
        end
    endtask

    task automatic test_empty_stall();
        int exp_cc;
        force_empty = 1'b1;
        pulse_start(2'd0, 32'h0, 1'b1);
        exp_cc = 0;
        for (int i = 0; i < 12; i++) begin
            to_negedge();
            total++;
            if (done !== 1'b0 || busy !== 1'b1 || snk_rd_en !== 1'b0) begin
                bad++;
                $display("[TB] FAIL empty_stall cycle %0d: got done=%b busy=%b rd=%b want 0/1/0", i, done, busy, snk_rd_en);
            end
            to_posedge();
            exp_cc++;
            total++;
            if (cycle_count !== 32'(exp_cc)) begin
                bad++;
                $display("[TB] FAIL empty_cycle_count: got %0d want %0d", cycle_count, exp_cc);
            end
        end
        force_empty = 1'b0;
        wait_done("empty", 50);
    endtask

    task automatic test_reset_midframe();
        pulse_start(2'd0, 32'h0, 1'b1);
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({busy, done, overrun, src_wr_en, snk_rd_en} !== 5'b0 || src_din !== 24'h0) begin
            bad++;
            $display("[TB] FAIL async_reset_outputs: got %b/%h want 00000/000000", {busy, done, overrun, src_wr_en, snk_rd_en}, src_din);
        end
        total++;
        if (cycle_count !== 32'h0 || checksum !== 32'h0) begin
            bad++;
            $display("[TB] FAIL async_reset_counters: got %h/%h want 0/0", cycle_count, checksum);
        end
        exp_q.delete();
        to_posedge();
        reset = 1'b0;
        to_posedge();
        pulse_start(2'd0, 32'h0, 1'b1);
        wait_done("restart", 50);
        total++;
        if (checksum !== 32'h001F_1C09) begin
            bad++;
            $display("[TB] FAIL restart_checksum_const: got %h want 001f1c09", checksum);
        end
    endtask

    task automatic test_overrun();
        inject_data = 24'hABCDEF;
        inject_en   = 1'b1;
        to_posedge();
        inject_en  = 1'b0;
        fifo_flush = 1'b1;
        @(negedge clock);
        total++;
        if (snk_rd_en !== 1'b0 || done !== 1'b1 || snk_empty !== 1'b0) begin
            bad++;
            $display("[TB] FAIL overrun_rd_en: got rd=%b done=%b empty=%b want 0/1/0", snk_rd_en, done, snk_empty);
        end
        to_posedge();
        fifo_flush = 1'b0;
        @(negedge clock);
        total++;
        if (overrun !== 1'b1) begin
            bad++;
            $display("[TB] FAIL overrun_set: got %b want 1", overrun);
        end
        to_posedge();
        step();
        step();
        total++;
        if (overrun !== 1'b1 || snk_empty !== 1'b1) begin
            bad++;
            $display("[TB] FAIL overrun_sticky: got %b empty=%b want 1/1", overrun, snk_empty);
        end
        pulse_start(2'd0, 32'h0, 1'b1);
        total++;
        if (overrun !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL overrun_clear: got %b busy=%b want 0/1", overrun, busy);
        end
        wait_done("after_overrun", 50);
    endtask

    task automatic test_lfsr();
        pulse_start(2'd2, 32'h0, 1'b1);
        @(negedge clock);
        total++;
        if (src_din !== 24'h000001) begin
            bad++;
            $display("[TB] FAIL lfsr_first: got %h want 000001", src_din);
        end
        to_negedge_same_time();
        to_posedge();
        mode  = 2'd0;
        seed  = 32'h0000_00FF;
        start = 1'b1;
        step();
        start = 1'b0;
        mode  = 2'd2;
        seed  = 32'h0;
        total++;
        if (busy !== 1'b1 || cycle_count !== 32'd2) begin
            bad++;
            $display("[TB] FAIL start_in_run: got busy=%b cc=%0d want 1/2", busy, cycle_count);
        end
        wait_done("lfsr", 50);
    endtask

    task automatic test_constant_and_reserved();
        pulse_start(2'd1, 32'hA5B6_C7D8, 1'b1);
        wait_done("constant", 50);
        pulse_start(2'd3, 32'h1234_5678, 1'b1);
        wait_done("reserved", 50);
        total++;
        if (checksum !== 32'h001F_1C09) begin
            bad++;
            $display("[TB] FAIL reserved_checksum_const: got %h want 001f1c09", checksum);
        end
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        mode        = 2'd0;
        seed        = 32'h0;
        force_full  = 1'b0;
        force_empty = 1'b0;
        inject_en   = 1'b0;
        fifo_flush  = 1'b0;
        inject_data = 24'h0;
        exp_sum     = 32'h0;

        test_reset();
        test_ramp_frame();
        test_full_backpressure();
        test_empty_stall();
        test_reset_midframe();
        test_overrun();
        test_lfsr();
        test_constant_and_reserved();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
